// File: rtl/payload_pkg.sv
// Shared types and helpers for the payload streamer.
//
// Contents:
//   state_e     - controller state: FILL (host loading) / STREAM (replaying)
//   beat_width  - bits per beat, CHANNELS * ITEM_WIDTH
//   CSUM_W      - width of the optional streamed-data checksum
package payload_pkg;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } state_e;

   localparam int CSUM_W = 16;

   function automatic int beat_width(input int channels, input int item_width);
      return channels * item_width;
   endfunction

endpackage

// File: rtl/payload_buf.sv
// Beat storage for the payload streamer: simple dual-port memory of
// DEPTH x WIDTH with one synchronous write port and one registered read
// port (data appears one cycle after the address is presented).
//
// Ports:
//   clk_i      - clock
//   reset_i    - asynchronous active-high reset (clears the read register)
//   wr_en_i    - write enable
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address, sampled every cycle
//   rd_data_o  - registered read data
module payload_buf #(
   parameter int DEPTH  = 100,
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 7
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/payload_streamer.sv
// Stimulus buffer: collects a batch of up to NUM beats from the host, then
// replays it on a valid/ready stream at one beat per cycle.
//
// Handshake rule (both sides): a beat transfers on a rising edge where
// valid && ready; once out_valid_o is high, out_data_o and out_last_o hold
// until that transfer.
//
// Ports:
//   clk_i, reset_i           - clock, asynchronous active-high reset
//   load_valid_i/ready_o     - host load handshake (ready only in FILL)
//   load_data_i, load_last_i - load beat and batch-close flag
//   out_valid_o/ready_i      - stream handshake towards the BFM
//   out_data_o, out_last_o   - stream beat and final-beat flag
//   xmit_en_o                - host may load (FILL state)
//   done_o                   - one-cycle pulse after the last stream beat
//   batch_len_o              - beats in the current/last batch
//   checksum_o               - only with PAYLOAD_STREAMER_CHECKSUM_EN defined:
//                              16-bit sum of all streamed items
module payload_streamer
   import payload_pkg::*;
#(
   parameter int NUM        = 100,
   parameter int CHANNELS   = 2,
   parameter int ITEM_WIDTH = 8
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           load_valid_i,
   output logic                           load_ready_o,
   input  logic [CHANNELS*ITEM_WIDTH-1:0] load_data_i,
   input  logic                           load_last_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [CHANNELS*ITEM_WIDTH-1:0] out_data_o,
   output logic                           out_last_o,
   output logic                           xmit_en_o,
   output logic                           done_o,
   output logic [$clog2(NUM+1)-1:0]       batch_len_o
`ifdef PAYLOAD_STREAMER_CHECKSUM_EN
   ,
   output logic [CSUM_W-1:0]              checksum_o
`endif
);

   localparam int BW    = beat_width(CHANNELS, ITEM_WIDTH);
   localparam int LEN_W = $clog2(NUM + 1);
   localparam int AW    = $clog2(NUM);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
   // Index of the beat currently presented on the output.
   logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             out_valid_q, out_valid_d;
   logic             done_q, done_d;

   logic             wr_en;
   logic [AW-1:0]    rd_addr;
   logic [BW-1:0]    rd_data;
   logic [LEN_W-1:0] rd_next;
   logic             load_fire;
   logic             out_fire;
   logic             is_last;

   assign load_fire = (state_q == FILL) && load_valid_i;
   assign out_fire  = out_valid_q && out_ready_i;
   assign is_last   = (rd_ptr_q == (len_q - LEN_W'(1)));
   assign rd_next   = rd_ptr_q + LEN_W'(1);

   payload_buf #(
      .DEPTH  (NUM),
      .WIDTH  (BW),
      .ADDR_W (AW)
   ) u_buf (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (load_data_i),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= FILL;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         len_q       <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         len_q       <= len_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   // The memory read register doubles as the output data register: the
   // read address is steered to the beat that must be visible next cycle
   // (same beat while stalled, next beat on a handshake), which hides the
   // read latency without bubbles and keeps data stable under backpressure.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      len_d       = len_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      wr_en       = 1'b0;
      rd_addr     = rd_ptr_q[AW-1:0];

      case (state_q)
         FILL: begin
            if (load_fire) begin
               wr_en    = 1'b1;
               wr_ptr_d = rd_next_fill(wr_ptr_q);
               // wr_ptr_q is zero on the first beat of a batch, so the
               // length restarts at 1 without a separate flag.
               len_d    = rd_next_fill(wr_ptr_q);
               if (load_last_i || (wr_ptr_q == LEN_W'(NUM - 1))) begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (!out_valid_q) begin
               // First STREAM cycle: fetch beat 0.
               out_valid_d = 1'b1;
            end else if (out_fire) begin
               if (is_last) begin
                  out_valid_d = 1'b0;
                  state_d     = FILL;
                  wr_ptr_d    = '0;
                  rd_ptr_d    = '0;
                  done_d      = 1'b1;
               end else begin
                  rd_ptr_d = rd_next;
                  rd_addr  = rd_next[AW-1:0];
               end
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   function automatic logic [LEN_W-1:0] rd_next_fill(input logic [LEN_W-1:0] p);
      return p + LEN_W'(1);
   endfunction

   assign load_ready_o = (state_q == FILL);
   assign xmit_en_o    = (state_q == FILL);
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_valid_q ? rd_data : '0;
   assign out_last_o   = out_valid_q && is_last;
   assign done_o       = done_q;
   assign batch_len_o  = len_q;

`ifdef PAYLOAD_STREAMER_CHECKSUM_EN
   logic [CSUM_W-1:0] csum_q, csum_d;
   logic [CSUM_W-1:0] beat_sum;

   always_comb begin
      beat_sum = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         beat_sum = beat_sum + CSUM_W'(rd_data[k*ITEM_WIDTH +: ITEM_WIDTH]);
      end
   end

   always_comb begin
      csum_d = csum_q;
      if (load_fire && (wr_ptr_q == '0)) begin
         csum_d = '0;
      end else if (out_fire) begin
         csum_d = csum_q + beat_sum;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_payload_streamer.sv
// Self-checking bench for payload_streamer (NUM=4, CHANNELS=2, ITEM_WIDTH=8).
// Beats are issued by driver tasks; the expected stream is pushed to a
// scoreboard queue and checked by an independent negedge monitor.
module tb_payload_streamer;

  localparam int NUM = 4;
  localparam int CH  = 2;
  localparam int IW  = 8;
  localparam int BW  = CH * IW;
  localparam int LW  = $clog2(NUM + 1);

  logic          clk;
  logic          reset_i;
  logic          load_valid_i;
  logic          load_ready_o;
  logic [BW-1:0] load_data_i;
  logic          load_last_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [BW-1:0] out_data_o;
  logic          out_last_o;
  logic          xmit_en_o;
  logic          done_o;
  logic [LW-1:0] batch_len_o;
`ifdef PAYLOAD_STREAMER_CHECKSUM_EN
  logic [15:0]   checksum_o;
`endif

  payload_streamer #(
    .NUM        (NUM),
    .CHANNELS   (CH),
    .ITEM_WIDTH (IW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_data_i  (load_data_i),
    .load_last_i  (load_last_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .xmit_en_o    (xmit_en_o),
    .done_o       (done_o),
    .batch_len_o  (batch_len_o)
`ifdef PAYLOAD_STREAMER_CHECKSUM_EN
    ,
    .checksum_o   (checksum_o)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  logic [BW:0]   exp_q[$];       // {last, data}
  logic [LW-1:0] exp_len_q[$];
  logic [15:0]   exp_csum_q[$];

  logic [BW-1:0] beat_buf [NUM];

  // ---------------- ready driver ----------------
  // 0: manual_ready, 1: always 1, 2: random, 3: fixed pattern
  int   ready_mode   = 0;
  logic manual_ready = 1'b0;
  int   pat [6]      = '{1, 0, 0, 1, 0, 1};
  int   pat_i        = 0;

  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       out_ready_i = 1'b1;
        2:       out_ready_i = 1'($urandom_range(0, 1));
        3: begin
          out_ready_i = (pat[pat_i % 6] != 0);
          pat_i++;
        end
        default: out_ready_i = manual_ready;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic          prev_valid, prev_ready, prev_last, prev_hs_last, prev_hs_nonlast;
  logic [BW-1:0] prev_data;
  initial begin
    prev_valid = 0; prev_ready = 0; prev_last = 0;
    prev_hs_last = 0; prev_hs_nonlast = 0; prev_data = '0;
  end

  always @(negedge clk) begin
    logic [BW:0] e;
    logic        hs;
    logic        e_last;
    if (reset_i) begin
      prev_valid = 0; prev_ready = 0; prev_last = 0;
      prev_hs_last = 0; prev_hs_nonlast = 0;
    end else begin
      check("done_pulse", done_o, prev_hs_last);
      if (prev_hs_last) begin
        check("xmit_en_after_done", xmit_en_o, 1);
        check("load_ready_after_done", load_ready_o, 1);
        if (exp_len_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL batch_len: done with no expected batch");
        end else begin
          check("batch_len_at_done", batch_len_o, exp_len_q.pop_front());
        end
`ifdef PAYLOAD_STREAMER_CHECKSUM_EN
        if (exp_csum_q.size() != 0) check("checksum_at_done", checksum_o, exp_csum_q.pop_front());
`endif
      end
      if (prev_hs_nonlast) check("no_bubble", out_valid_o, 1);
      if (prev_valid && !prev_ready) begin
        check("stall_valid", out_valid_o, 1);
        check("stall_data", out_data_o, prev_data);
        check("stall_last", out_last_o, prev_last);
      end
      hs     = out_valid_o && out_ready_i;
      e_last = 1'b0;
      if (hs) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h, expected none", out_data_o);
        end else begin
          e = exp_q.pop_front();
          e_last = e[BW];
          check("beat_data", out_data_o, e[BW-1:0]);
          check("beat_last", out_last_o, e[BW]);
        end
      end
      prev_hs_last    = hs && e_last;
      prev_hs_nonlast = hs && !e_last;
      prev_valid      = out_valid_o;
      prev_ready      = out_ready_i;
      prev_data       = out_data_o;
      prev_last       = out_last_o;
    end
  end

  // ---------------- driver tasks ----------------
  // Loads beat_buf[0..n-1]; the model expects every batch to stream in load
  // order with last on its final beat (explicit or auto-closed at NUM).
  task automatic load_batch(input int n, input bit set_last);
    logic [15:0] cs;
    int t;
    cs = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, beat_buf[i]});
      for (int k = 0; k < CH; k++) cs = cs + 16'(beat_buf[i][k*IW +: IW]);
    end
    exp_len_q.push_back(LW'(n));
    exp_csum_q.push_back(cs);
    @(posedge clk); #1;
    t = 0;
    while (!load_ready_o && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!load_ready_o) begin
      n_checks++; n_fail++;
      $display("FAIL load_wait: load_ready_o stuck at 0, expected 1");
      return;
    end
    check("xmit_en_in_fill", xmit_en_o, 1);
    for (int i = 0; i < n; i++) begin
      load_valid_i = 1'b1;
      load_data_i  = beat_buf[i];
      load_last_i  = (i == n - 1) ? set_last : 1'b0;
      @(posedge clk); #1;
      check("batch_len_load", batch_len_o, i + 1);
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    check("load_ready_closed", load_ready_o, 0);
    check("xmit_en_closed", xmit_en_o, 0);
    check("valid_not_yet", out_valid_o, 0);
    @(posedge clk); #1;
    check("first_valid", out_valid_o, 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!done_o) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: done_o stayed 0, expected pulse");
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_load_ready"}, load_ready_o, 1);
    check({tag, "_xmit_en"}, xmit_en_o, 1);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_out_last"}, out_last_o, 0);
    check({tag, "_out_data"}, out_data_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_batch_len"}, batch_len_o, 0);
`ifdef PAYLOAD_STREAMER_CHECKSUM_EN
    check({tag, "_checksum"}, checksum_o, 0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int hs0;
    int n;
    bit lst;
    reset_i      = 1'b1;
    load_valid_i = 1'b0;
    load_data_i  = '0;
    load_last_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_i = 1'b0;

    // Basic three-beat batch, always ready.
    ready_mode  = 1;
    beat_buf[0] = 16'h0201;
    beat_buf[1] = 16'h0403;
    beat_buf[2] = 16'h0605;
    load_batch(3, 1'b1);
    wait_done();

    // Auto-close after NUM beats; a further load attempt is refused.
    for (int i = 0; i < NUM; i++) beat_buf[i] = 16'($urandom);
    load_batch(NUM, 1'b0);
    load_valid_i = 1'b1;
    load_data_i  = 16'hEEEE;
    load_last_i  = 1'b1;
    check("stream_load_ready_0", load_ready_o, 0);
    @(posedge clk); #1;
    check("stream_load_ready_1", load_ready_o, 0);
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    wait_done();

    // Backpressure with ready pattern 1,0,0,1,0,1 from the first valid beat.
    ready_mode   = 0;
    manual_ready = 1'b0;
    for (int i = 0; i < 3; i++) beat_buf[i] = 16'($urandom);
    load_batch(3, 1'b1);
    pat_i      = 0;
    ready_mode = 3;
    hs0        = n_hs;
    wait_done();
    check("backpressure_handshakes", n_hs - hs0, 3);
    ready_mode = 1;

    // Single-beat batch.
    beat_buf[0] = 16'h01FF;
    load_batch(1, 1'b1);
    wait_done();

    // Reset after one of three beats has been sent.
    ready_mode   = 0;
    manual_ready = 1'b0;
    for (int i = 0; i < 3; i++) beat_buf[i] = 16'($urandom);
    load_batch(3, 1'b1);
    manual_ready = 1'b1;
    @(posedge clk); #1;
    manual_ready = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    check_reset_values("midreset");
    exp_q.delete();
    exp_len_q.delete();
    exp_csum_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    reset_i    = 1'b0;
    ready_mode = 1;
    beat_buf[0] = 16'h0807;
    beat_buf[1] = 16'h0A09;
    load_batch(2, 1'b1);
    wait_done();

    // Back-to-back: B starts loading the cycle xmit_en_o rises after A.
    beat_buf[0] = 16'h1111;
    beat_buf[1] = 16'h2222;
    load_batch(2, 1'b1);
    beat_buf[0] = 16'h3333;
    load_batch(1, 1'b1);
    wait_done();

    // Randomised batches with random backpressure.
    ready_mode = 2;
    for (int b = 0; b < 25; b++) begin
      n   = $urandom_range(1, NUM);
      lst = (n < NUM) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) beat_buf[i] = 16'($urandom);
      load_batch(n, lst);
    end
    ready_mode = 1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_xmit_en", xmit_en_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
